// File: rtl/nios_base_cpu_jtag_pkg.sv
// Shared definitions for the JTAG monitor memory access block: FSM states,
// jdo bit positions and command priority ranks.
package nios_base_cpu_jtag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } mon_state_e;

    typedef enum logic [1:0] {
        CMD_NONE      = 2'd0,
        CMD_NO_ACTION = 2'd1,
        CMD_A         = 2'd2,
        CMD_B         = 2'd3
    } mon_cmd_e;

    localparam int JDO_W      = 38;
    localparam int ADDR_LSB   = 17;
    localparam int RD_BIT     = 34;
    localparam int ERRCLR_BIT = 35;
    localparam int WDATA_LSB  = 3;

    // Bit rank of each pulse in the pulse vector; the highest set rank wins.
    localparam int PRIO_B  = 2;
    localparam int PRIO_A  = 1;
    localparam int PRIO_NA = 0;

    function automatic mon_cmd_e pick_cmd(input logic pulse_a, input logic pulse_b,
                                          input logic pulse_na);
        logic [2:0] pulses;
        pulses          = '0;
        pulses[PRIO_B]  = pulse_b;
        pulses[PRIO_A]  = pulse_a;
        pulses[PRIO_NA] = pulse_na;
        if (pulses[PRIO_B])       return CMD_B;
        else if (pulses[PRIO_A])  return CMD_A;
        else if (pulses[PRIO_NA]) return CMD_NO_ACTION;
        else                      return CMD_NONE;
    endfunction

endpackage

// File: rtl/nios_base_cpu_jtag_mon_access_if.sv
// Monitor memory port between the JTAG access block (master) and the memory.
interface nios_base_cpu_jtag_mon_access_if #(
    parameter int ADDR_W = 8
);
    // A strobe (mem_read or mem_write) stays high until the first cycle in
    // which mem_waitrequest is low; that cycle is the accept, and on reads
    // mem_readdata must be valid in that same cycle.
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
    logic              mem_waitrequest;

    modport master (
        output mem_address, mem_read, mem_write, mem_writedata,
        input  mem_readdata, mem_waitrequest
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_writedata,
        output mem_readdata, mem_waitrequest
    );
endinterface

// File: rtl/nios_base_cpu_jtag_mon_access.sv
// JTAG monitor memory access FSM: turns debug command pulses into single memory
// reads/writes. Define JTAG_MON_TIMEOUT_EN to abort accesses stalled TIMEOUT_CYC cycles.
module nios_base_cpu_jtag_mon_access
    import nios_base_cpu_jtag_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [JDO_W-1:0]                       jdo,
    input  logic                                   take_action_ocimem_a,
    input  logic                                   take_action_ocimem_b,
    input  logic                                   take_no_action_ocimem_a,
    nios_base_cpu_jtag_mon_access_if.master        mem,
    output logic [31:0]                            MonDReg,
    output logic                                   monitor_ready,
    output logic                                   monitor_error,
    output mon_state_e                             dbg_state
);

    mon_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mon_d;
    logic              err_q, err_d;
    logic              inc_q, inc_d;
    logic              timeout_hit;
    mon_cmd_e          cmd;
    logic              any_pulse;

    logic unused_jdo_bits;
    assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

`ifdef JTAG_MON_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = '0;
        timeout_hit = 1'b0;
        if (state_q != ST_IDLE && mem.mem_waitrequest) begin
            if (stall_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) timeout_hit = 1'b1;
            else                                        stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout_hit = 1'b0;
`endif

    assign cmd       = pick_cmd(take_action_ocimem_a, take_action_ocimem_b,
                                take_no_action_ocimem_a);
    assign any_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mon_d   = MonDReg;
        err_d   = err_q;
        inc_d   = inc_q;
        unique case (state_q)
            ST_IDLE: begin
                unique case (cmd)
                    CMD_B: begin
                        wdata_d = jdo[WDATA_LSB +: 32];
                        inc_d   = 1'b1;
                        state_d = ST_WRITE;
                    end
                    CMD_A: begin
                        addr_d = jdo[ADDR_LSB +: ADDR_W];
                        if (jdo[RD_BIT]) begin
                            inc_d   = 1'b0;
                            state_d = ST_READ;
                        end
                        if (jdo[ERRCLR_BIT]) err_d = 1'b0;
                    end
                    CMD_NO_ACTION: begin
                        inc_d   = 1'b1;
                        state_d = ST_READ;
                    end
                    default: ;
                endcase
            end
            ST_READ, ST_WRITE: begin
                // Commands cannot be queued while an access is in flight.
                if (any_pulse) err_d = 1'b1;
                if (!mem.mem_waitrequest) begin
                    state_d = ST_IDLE;
                    if (state_q == ST_READ) mon_d = mem.mem_readdata;
                    if (inc_q)              addr_d = addr_q + 1'b1;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            MonDReg <= '0;
            err_q   <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            MonDReg <= mon_d;
            err_q   <= err_d;
            inc_q   <= inc_d;
        end
    end

    assign mem.mem_address   = addr_q;
    assign mem.mem_read      = (state_q == ST_READ);
    assign mem.mem_write     = (state_q == ST_WRITE);
    assign mem.mem_writedata = wdata_q;
    assign monitor_ready     = (state_q == ST_IDLE);
    assign monitor_error     = err_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_nios_base_cpu_jtag_mon_access.sv
// Directed bench for the JTAG monitor access block; the timeout section runs
// only when JTAG_MON_TIMEOUT_EN is defined.
module tb_nios_base_cpu_jtag_mon_access;
    import nios_base_cpu_jtag_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta_a, ta_b, tna_a;
    logic [31:0] mon_dreg;
    logic        mon_ready, mon_error;
    mon_state_e  dbg_state;
    int          checks;
    int          errors;

    nios_base_cpu_jtag_mon_access_if #(.ADDR_W(8)) mem_bus ();

    nios_base_cpu_jtag_mon_access #(.ADDR_W(8), .TIMEOUT_CYC(4)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tna_a),
        .mem                     (mem_bus),
        .MonDReg                 (mon_dreg),
        .monitor_ready           (mon_ready),
        .monitor_error           (mon_error),
        .dbg_state               (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] j;
        j        = '0;
        j[24:17] = a;
        j[34]    = rd;
        j[35]    = clr;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] j);
        jdo   = j;
        ta_a  = a;
        ta_b  = b;
        tna_a = na;
        tick();
        ta_a  = 1'b0;
        ta_b  = 1'b0;
        tna_a = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_read"},   32'(mem_bus.mem_read), 32'd0);
        check({tag, "_write"},  32'(mem_bus.mem_write), 32'd0);
        check({tag, "_addr"},   32'(mem_bus.mem_address), 32'd0);
        check({tag, "_wdata"},  mem_bus.mem_writedata, 32'd0);
        check({tag, "_mondreg"}, mon_dreg, 32'd0);
        check({tag, "_ready"},  32'(mon_ready), 32'd1);
        check({tag, "_error"},  32'(mon_error), 32'd0);
        check({tag, "_state"},  32'(dbg_state), 32'(ST_IDLE));
    endtask

    logic [7:0] exp_addr [3];

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        jdo = '0;
        ta_a = 1'b0;
        ta_b = 1'b0;
        tna_a = 1'b0;
        mem_bus.mem_readdata = 32'h0;
        mem_bus.mem_waitrequest = 1'b0;
        exp_addr[0] = 8'hFE;
        exp_addr[1] = 8'hFF;
        exp_addr[2] = 8'h00;

        // Reset state
        tick();
        tick();
        check_reset_values("rst");
        reset_n = 1'b1;
        tick();

        // Load address 0x10 with read
        mem_bus.mem_readdata = 32'hCAFE0001;
        pulse(1'b1, 1'b0, 1'b0, mk_a(8'h10, 1'b1, 1'b0));
        check("a_rd_strobe", 32'(mem_bus.mem_read), 32'd1);
        check("a_rd_addr",   32'(mem_bus.mem_address), 32'h10);
        check("a_rd_ready",  32'(mon_ready), 32'd0);
        tick();
        check("a_rd_done",    32'(mem_bus.mem_read), 32'd0);
        check("a_rd_mondreg", mon_dreg, 32'hCAFE0001);
        check("a_rd_noinc",   32'(mem_bus.mem_address), 32'h10);
        check("a_rd_ready2",  32'(mon_ready), 32'd1);

        // Three writes from 0xFE, wrapping
        mem_bus.mem_readdata = 32'hDEADBEEF;
        pulse(1'b1, 1'b0, 1'b0, mk_a(8'hFE, 1'b0, 1'b0));
        check("a_load_addr",  32'(mem_bus.mem_address), 32'hFE);
        check("a_load_idle",  32'(dbg_state), 32'(ST_IDLE));
        check("a_load_noread", 32'(mem_bus.mem_read), 32'd0);
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1, 1'b0, mk_b(32'(i + 1)));
            check("b_wr_strobe", 32'(mem_bus.mem_write), 32'd1);
            check("b_wr_addr",   32'(mem_bus.mem_address), 32'(exp_addr[i]));
            check("b_wr_data",   mem_bus.mem_writedata, 32'(i + 1));
            tick();
            check("b_wr_done",   32'(mem_bus.mem_write), 32'd0);
        end
        check("b_addr_end",    32'(mem_bus.mem_address), 32'h01);
        check("b_mondreg_kept", mon_dreg, 32'hCAFE0001);

        // Read-next with 5 stalled cycles
        mem_bus.mem_readdata = 32'h12345678;
        mem_bus.mem_waitrequest = 1'b1;
        pulse(1'b0, 1'b0, 1'b1, 38'h0);
        for (int i = 0; i < 5; i++) begin
            check("na_stall_read",  32'(mem_bus.mem_read), 32'd1);
            check("na_stall_ready", 32'(mon_ready), 32'd0);
            check("na_stall_mondreg", mon_dreg, 32'hCAFE0001);
            tick();
        end
        mem_bus.mem_waitrequest = 1'b0;
        check("na_6th_read", 32'(mem_bus.mem_read), 32'd1);
        check("na_6th_addr", 32'(mem_bus.mem_address), 32'h01);
        tick();
        check("na_done_read",  32'(mem_bus.mem_read), 32'd0);
        check("na_mondreg",    mon_dreg, 32'h12345678);
        check("na_addr_inc",   32'(mem_bus.mem_address), 32'h02);
        check("na_ready",      32'(mon_ready), 32'd1);

        // ocimem_b beats no_action; pulse during WRITE sets error
        mem_bus.mem_waitrequest = 1'b1;
        pulse(1'b0, 1'b1, 1'b1, mk_b(32'hA5A5A5A5));
        check("prio_write", 32'(mem_bus.mem_write), 32'd1);
        check("prio_noread", 32'(mem_bus.mem_read), 32'd0);
        check("prio_wdata", mem_bus.mem_writedata, 32'hA5A5A5A5);
        check("prio_noerr", 32'(mon_error), 32'd0);
        pulse(1'b0, 1'b0, 1'b1, 38'h0);
        check("busy_err",   32'(mon_error), 32'd1);
        check("busy_write", 32'(mem_bus.mem_write), 32'd1);
        mem_bus.mem_waitrequest = 1'b0;
        tick();
        check("busy_idle",    32'(dbg_state), 32'(ST_IDLE));
        check("busy_addr",    32'(mem_bus.mem_address), 32'h03);
        check("busy_sticky",  32'(mon_error), 32'd1);
        check("busy_mondreg", mon_dreg, 32'h12345678);
        tick();
        check("sticky_idle", 32'(mon_error), 32'd1);
        pulse(1'b1, 1'b0, 1'b0, mk_a(8'h40, 1'b0, 1'b1));
        check("errclr",      32'(mon_error), 32'd0);
        check("errclr_addr", 32'(mem_bus.mem_address), 32'h40);
        check("errclr_idle", 32'(dbg_state), 32'(ST_IDLE));

        // ocimem_a beats no_action: read at new address, no increment
        mem_bus.mem_readdata = 32'h0BADF00D;
        pulse(1'b1, 1'b0, 1'b1, mk_a(8'h20, 1'b1, 1'b0));
        check("prio_a_read", 32'(mem_bus.mem_read), 32'd1);
        check("prio_a_addr", 32'(mem_bus.mem_address), 32'h20);
        tick();
        check("prio_a_mondreg", mon_dreg, 32'h0BADF00D);
        check("prio_a_noinc",   32'(mem_bus.mem_address), 32'h20);
        check("prio_a_noerr",   32'(mon_error), 32'd0);

`ifdef JTAG_MON_TIMEOUT_EN
        // Stuck waitrequest aborts after 4 stalled cycles
        mem_bus.mem_readdata = 32'h55555555;
        mem_bus.mem_waitrequest = 1'b1;
        pulse(1'b0, 1'b0, 1'b1, 38'h0);
        for (int i = 0; i < 4; i++) begin
            check("to_stall_read", 32'(mem_bus.mem_read), 32'd1);
            tick();
        end
        check("to_dropped",  32'(mem_bus.mem_read), 32'd0);
        check("to_state",    32'(dbg_state), 32'(ST_IDLE));
        check("to_error",    32'(mon_error), 32'd1);
        check("to_mondreg",  mon_dreg, 32'h0BADF00D);
        check("to_addr",     32'(mem_bus.mem_address), 32'h20);
        pulse(1'b1, 1'b0, 1'b0, mk_a(8'h20, 1'b0, 1'b1));
        check("to_errclr",   32'(mon_error), 32'd0);
        mem_bus.mem_waitrequest = 1'b0;
`endif

        // Asynchronous reset in the middle of a stalled read
        mem_bus.mem_waitrequest = 1'b1;
        pulse(1'b0, 1'b0, 1'b1, 38'h0);
        check("mid_read", 32'(mem_bus.mem_read), 32'd1);
        pulse(1'b0, 1'b1, 1'b0, mk_b(32'h77777777));
        check("mid_err",  32'(mon_error), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_read", 32'(mem_bus.mem_read), 32'd0);
        check("post_rst_idle", 32'(dbg_state), 32'(ST_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
